issue_hazard_scoreboard: RTL and testbench

- Parametrised hazard/issue unit for the W-wide superscalar MIPS pipeline. Sits in the ID stage.
- Replaces the fixed two-slot combinational hazard logic with:
  - a per-register load scoreboard;
  - in-order partial (split) issue of a bundle;
  - an internal replay state. This supersedes the external bubble flag.
- Drives PC/IF-ID enables and the per-slot control-or-NOP select. Also keeps a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 68 ++++++
 rtl/issue_hazard_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_issue_hazard_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the ID-stage issue/hazard unit.
//   hz_state_e : issue FSM states (FRESH bundle / REPLAY of a split bundle)
//   SB_CNT_W   : width of a per-register load scoreboard counter (LOAD_LAT <= 3)
//   slot_reg() : extract slot k's register field from a packed per-slot vector
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int unsigned DEF_REG_AW  = 5;
    localparam int unsigned MAX_REG_AW  = 8;
    localparam int unsigned MAX_ISSUE_W = 4;
    localparam int unsigned SLOT_VEC_W  = MAX_ISSUE_W * MAX_REG_AW;
    localparam int unsigned SB_CNT_W    = 2;

    typedef enum logic [0:0] {
        FRESH  = 1'b0,
        REPLAY = 1'b1
    } hz_state_e;

    // Slot k's field starts at bit k*aw; shifting it to the bottom and keeping
    // MAX_REG_AW bits lets the caller truncate to its own register width.
    function automatic logic [MAX_REG_AW-1:0] slot_reg(
        input logic [SLOT_VEC_W-1:0] vec,
        input int unsigned           k,
        input int unsigned           aw
    );
        logic [SLOT_VEC_W-1:0] shifted;
        shifted = vec >> (k * aw);
        return shifted[MAX_REG_AW-1:0];
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register load down-counters. A register is busy while its counter is
// non-zero. An issuing load to r (r != 0) reloads cnt[r] with LOAD_LAT; that
// reload takes priority over the free-running decrement.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears all counters)
//   set_valid   : per-slot "issuing load" strobes
//   set_addr    : per-slot destination registers, slot s at [s*REG_AW +: REG_AW]
//   busy        : one busy bit per architectural register (bit 0 always 0)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NSET     = 2,
    parameter int unsigned REG_AW   = hazard_pkg::DEF_REG_AW,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSET-1:0]          set_valid,
    input  logic [NSET*REG_AW-1:0]   set_addr,
    output logic [(2**REG_AW)-1:0]   busy
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [SB_CNT_W-1:0] cnt_q [NREG];
    logic [SB_CNT_W-1:0] cnt_d [NREG];

    // Next counter values: decrement toward zero, reload on an issuing load.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (cnt_q[r] != SB_CNT_W'(0)) begin
                cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
            end else begin
                cnt_d[r] = SB_CNT_W'(0);
            end
            for (int unsigned s = 0; s < NSET; s++) begin
                if (set_valid[s] && (r != 0) && (set_addr[s*REG_AW +: REG_AW] == REG_AW'(r))) begin
                    cnt_d[r] = SB_CNT_W'(LOAD_LAT);
                end else begin
                    cnt_d[r] = cnt_d[r];
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt_q[r] <= SB_CNT_W'(0);
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Busy decode; register 0 is hard-wired never busy.
    always_comb begin
        busy = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != SB_CNT_W'(0));
        end
    end

endmodule

// File: rtl/issue_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_hazard_scoreboard
// ID-stage issue unit for a W-wide in-order pipeline. Decides, per slot,
// whether to pass control to ID/EX or insert a NOP, based on a load
// scoreboard and older-slot RAW/WAW conflicts inside the bundle. A bundle
// that only partly issues is held in IF/ID and replayed with the issued
// slots masked off (REPLAY state).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : redirect; squashes the current ID bundle
//   id_valid            : per-slot valid, bit 0 = oldest
//   id_rs/id_rt/id_rw   : per-slot register fields, slot k at [k*REG_AW +: REG_AW]
//   id_rs_rd/id_rt_rd   : slot really reads rs / rt
//   id_reg_write        : slot writes rw
//   id_memread          : slot is a load
//   slot_issue          : 1 = pass control, 0 = NOP
//   pc_en, if_id_en     : front-end advance enables
//   partial             : registered, high while in REPLAY
//   stall_cycles        : saturating count of full-stall cycles
// -----------------------------------------------------------------------------
module issue_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned REG_AW   = hazard_pkg::DEF_REG_AW,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ISSUE_W-1:0]        id_valid,
    input  logic [ISSUE_W*REG_AW-1:0] id_rs,
    input  logic [ISSUE_W*REG_AW-1:0] id_rt,
    input  logic [ISSUE_W*REG_AW-1:0] id_rw,
    input  logic [ISSUE_W-1:0]        id_rs_rd,
    input  logic [ISSUE_W-1:0]        id_rt_rd,
    input  logic [ISSUE_W-1:0]        id_reg_write,
    input  logic [ISSUE_W-1:0]        id_memread,
    output logic [ISSUE_W-1:0]        slot_issue,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      partial,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int unsigned NREG = 2 ** REG_AW;

    hz_state_e          state_q, state_d;
    logic [ISSUE_W-1:0] done_mask_q, done_mask_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic [NREG-1:0]    busy;
    logic [ISSUE_W-1:0] eff;
    logic [ISSUE_W-1:0] sb_haz;
    logic [ISSUE_W-1:0] intra_haz;
    logic [ISSUE_W-1:0] can_issue;
    logic [ISSUE_W-1:0] sb_set;
    logic [REG_AW-1:0]  rs_a [ISSUE_W];
    logic [REG_AW-1:0]  rt_a [ISSUE_W];
    logic [REG_AW-1:0]  rw_a [ISSUE_W];
    logic               older_ok;

    // Unpack per-slot register fields.
    always_comb begin
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            rs_a[k] = REG_AW'(slot_reg(SLOT_VEC_W'(id_rs), k, REG_AW));
            rt_a[k] = REG_AW'(slot_reg(SLOT_VEC_W'(id_rt), k, REG_AW));
            rw_a[k] = REG_AW'(slot_reg(SLOT_VEC_W'(id_rw), k, REG_AW));
        end
    end

    // Hazard detection and in-order issue chain. A blocked effective slot
    // stops every younger slot; masked/invalid slots do not block.
    always_comb begin
        eff       = id_valid & ~done_mask_q;
        sb_haz    = '0;
        intra_haz = '0;
        can_issue = '0;
        older_ok  = 1'b1;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            sb_haz[k] = (id_rs_rd[k] & busy[rs_a[k]]) | (id_rt_rd[k] & busy[rt_a[k]]);
            for (int unsigned i = 0; i < k; i++) begin
                if (eff[i] && id_reg_write[i] && (rw_a[i] != REG_AW'(0))) begin
                    if ((id_rs_rd[k] && (rs_a[k] == rw_a[i])) ||
                        (id_rt_rd[k] && (rt_a[k] == rw_a[i])) ||
                        (id_reg_write[k] && (rw_a[k] == rw_a[i]))) begin
                        intra_haz[k] = 1'b1;
                    end else begin
                        intra_haz[k] = intra_haz[k];
                    end
                end else begin
                    intra_haz[k] = intra_haz[k];
                end
            end
            can_issue[k] = eff[k] & ~sb_haz[k] & ~intra_haz[k] & older_ok;
            if (eff[k] && !can_issue[k]) begin
                older_ok = 1'b0;
            end else begin
                older_ok = older_ok;
            end
        end
    end

    // Outcome: outputs and next state. rst, then flush, override the issue result.
    always_comb begin
        slot_issue  = '0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        state_d     = state_q;
        done_mask_d = done_mask_q;
        stall_d     = stall_q;
        if (rst) begin
            state_d     = FRESH;
            done_mask_d = '0;
            stall_d     = '0;
        end else if (flush) begin
            state_d     = FRESH;
            done_mask_d = '0;
        end else if (can_issue == eff) begin
            slot_issue  = can_issue;
            state_d     = FRESH;
            done_mask_d = '0;
        end else if (can_issue == '0) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            if (stall_q != {CNT_W{1'b1}}) begin
                stall_d = stall_q + CNT_W'(1);
            end else begin
                stall_d = stall_q;
            end
        end else begin
            slot_issue  = can_issue;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            state_d     = REPLAY;
            done_mask_d = done_mask_q | can_issue;
        end
    end

    // FSM, replay mask and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FRESH;
            done_mask_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            stall_q     <= stall_d;
        end
    end

    assign sb_set       = slot_issue & id_memread;
    assign partial      = (state_q == REPLAY);
    assign stall_cycles = stall_q;

    hazard_scoreboard #(
        .NSET     (ISSUE_W),
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (sb_set),
        .set_addr  (id_rw),
        .busy      (busy)
    );

endmodule

// File: tb/tb_issue_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_hazard_scoreboard
// Directed-vector bench for issue_hazard_scoreboard (ISSUE_W=2, LOAD_LAT=1).
// Inputs change 1 time unit after a rising edge; outputs are compared 1 unit
// later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_issue_hazard_scoreboard;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  id_valid;
    logic [W*AW-1:0] id_rs, id_rt, id_rw;
    logic [W-1:0]  id_rs_rd, id_rt_rd, id_reg_write, id_memread;
    logic [W-1:0]  slot_issue;
    logic          pc_en, if_id_en, partial;
    logic [31:0]   stall_cycles;

    int checks   = 0;
    int failures = 0;

    issue_hazard_scoreboard #(
        .ISSUE_W (W), .REG_AW (AW), .LOAD_LAT (1), .CNT_W (32)
    ) dut (
        .clk (clk), .rst (rst), .flush (flush), .id_valid (id_valid),
        .id_rs (id_rs), .id_rt (id_rt), .id_rw (id_rw),
        .id_rs_rd (id_rs_rd), .id_rt_rd (id_rt_rd),
        .id_reg_write (id_reg_write), .id_memread (id_memread),
        .slot_issue (slot_issue), .pc_en (pc_en), .if_id_en (if_id_en),
        .partial (partial), .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_all();
        id_valid = '0; id_rs = '0; id_rt = '0; id_rw = '0;
        id_rs_rd = '0; id_rt_rd = '0; id_reg_write = '0; id_memread = '0;
    endtask

    // One slot: valid, rs, rt, rw, reads rs, reads rt, writes rw, is load.
    task automatic set_slot(input int k, input logic v, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rw,
                            input logic rs_rd, input logic rt_rd,
                            input logic wr, input logic mem);
        id_valid[k]          = v;
        id_rs[k*AW +: AW]    = rs;
        id_rt[k*AW +: AW]    = rt;
        id_rw[k*AW +: AW]    = rw;
        id_rs_rd[k]          = rs_rd;
        id_rt_rd[k]          = rt_rd;
        id_reg_write[k]      = wr;
        id_memread[k]        = mem;
    endtask

    task automatic independent_bundle();
        clear_all();
        set_slot(0, 1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b0);
        set_slot(1, 1'b1, 5'd23, 5'd24, 5'd25, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic raw_bundle();
        clear_all();
        set_slot(0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); // add $3,$1,$2
        set_slot(1, 1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0); // sub $7,$3,$4
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        independent_bundle();
        // Reset held two cycles with a valid bundle present.
        tick(); tick();
        check("rst_issue",   32'(slot_issue), 32'd0);
        check("rst_pc_en",   32'(pc_en),      32'd1);
        check("rst_ifid_en", 32'(if_id_en),   32'd1);
        check("rst_partial", 32'(partial),    32'd0);
        check("rst_stall",   stall_cycles,    32'd0);

        rst = 1'b0; independent_bundle(); settle();
        check("indep_issue", 32'(slot_issue), 32'b11);
        check("indep_pc_en", 32'(pc_en),      32'd1);
        tick();

        // Empty bundle advances freely.
        clear_all(); settle();
        check("empty_issue", 32'(slot_issue), 32'b00);
        check("empty_pc_en", 32'(pc_en),      32'd1);
        tick();

        // Load-use across bundles.
        clear_all();
        set_slot(0, 1'b1, 5'd11, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        set_slot(1, 1'b1, 5'd2,  5'd0,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1); // lw $8
        settle();
        check("lw_issue", 32'(slot_issue), 32'b11);
        tick();
        clear_all();
        set_slot(0, 1'b1, 5'd8,  5'd14, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0); // reads $8
        set_slot(1, 1'b1, 5'd16, 5'd17, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("lu_issue",   32'(slot_issue), 32'b00);
        check("lu_pc_en",   32'(pc_en),      32'd0);
        check("lu_ifid_en", 32'(if_id_en),   32'd0);
        tick();
        check("lu_stall",   stall_cycles,    32'd1);
        check("lu_issue2",  32'(slot_issue), 32'b11);
        check("lu_pc_en2",  32'(pc_en),      32'd1);
        tick();

        // Intra-bundle RAW split.
        raw_bundle(); settle();
        check("raw_issue0",   32'(slot_issue), 32'b01);
        check("raw_pc_en0",   32'(pc_en),      32'd0);
        check("raw_partial0", 32'(partial),    32'd0);
        tick();
        check("raw_partial1", 32'(partial),    32'd1);
        check("raw_issue1",   32'(slot_issue), 32'b10);
        check("raw_pc_en1",   32'(pc_en),      32'd1);
        tick();
        check("raw_partial2", 32'(partial),    32'd0);

        // Register 0 never creates a dependency.
        clear_all();
        set_slot(0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_slot(1, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("r0_issue", 32'(slot_issue), 32'b11);
        tick();

        // WAW on $5 splits the bundle.
        clear_all();
        set_slot(0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        set_slot(1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("waw_issue0", 32'(slot_issue), 32'b01);
        tick();
        check("waw_issue1", 32'(slot_issue), 32'b10);
        check("waw_pc_en1", 32'(pc_en),      32'd1);
        tick();

        // Flush while replaying.
        raw_bundle(); settle();
        check("fl_issue0", 32'(slot_issue), 32'b01);
        tick();
        check("fl_partial1", 32'(partial), 32'd1);
        flush = 1'b1; settle();
        check("fl_issue",   32'(slot_issue), 32'b00);
        check("fl_pc_en",   32'(pc_en),      32'd1);
        check("fl_ifid_en", 32'(if_id_en),   32'd1);
        tick();
        flush = 1'b0; independent_bundle(); settle();
        check("fl_partial2", 32'(partial),    32'd0);
        check("fl_fresh",    32'(slot_issue), 32'b11);
        check("fl_stall",    stall_cycles,    32'd1);
        tick();

        // Reset in the middle of operation.
        clear_all();
        set_slot(0, 1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1); // lw $9
        settle();
        check("rm_lw_issue", 32'(slot_issue), 32'b01);
        tick();
        rst = 1'b1; settle();
        check("rm_rst_issue", 32'(slot_issue), 32'b00);
        tick();
        rst = 1'b0;
        clear_all();
        set_slot(0, 1'b1, 5'd9, 5'd1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("rm_issue", 32'(slot_issue), 32'b01);
        check("rm_stall", stall_cycles,    32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
